insn_fetch: RTL and testbench
=============================

# insn_fetch

Instruction fetch and decode stage for the 6502 core. Reads the opcode byte and 0–2 operand bytes from the CPU memory bus. Decodes each byte into a typepkg `Opcode` and `Addressing` value. Presents one complete instruction per valid/ready handshake to the downstream execute stage. It sits between the memory/bus arbiter and the execute sequencer, and is redirected by execute on jumps, branches, interrupts and the reset vector.

## Interface
- No parameters. Data width is `DATA_N` (8) from config.h; address width is fixed at 16.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pc_load`  in  1  redirect strobe from execute.
- `pc_in`  in  16  new fetch address, sampled when `pc_load`=1.
- `mem_addr`  out  16  read address.
- `mem_rd`  out  1  read request; `mem_data` is valid on the cycle after a request.
- `mem_data`  in  `DATA_N`  read data.
- `out_valid`  out  1  an instruction is presented.
- `out_ready`  in  1  execute accepts it.
- `out_op`  out  Opcode  decoded mnemonic.
- `out_mode`  out  Addressing  decoded addressing mode.
- `out_operand`  out  16  operand: 1-byte instruction = 0; 2-byte = {8'h00, lo}; 3-byte = {hi, lo}.
- `out_pc`  out  16  address of the opcode byte.
- `out_len`  out  2  instruction length, 1–3.

## Operation
- States: IDLE, FOP, WOP, WLO, WHI, OUT, HALT.
- Reset state: IDLE, pc=0, `mem_rd`=0, `out_valid`=0, `out_op`=NOP, `out_mode`=Imp, `out_operand`=0, `out_pc`=0, `out_len`=1.
- IDLE: no reads. Waits for `pc_load`.
- FOP: `mem_rd`=1, `mem_addr`=pc. Latches `out_pc`<=pc, pc<=pc+1. Next state is WOP.
- WOP: latches and decodes `mem_data`.
  - Length 1: go to OUT.
  - Otherwise, in the same cycle drive `mem_rd`=1, `mem_addr`=pc, pc<=pc+1, and go to WLO. Here `mem_rd` is combinational from the decoded `mem_data`.
- WLO: latches the low byte.
  - Length 3: issue a read of pc, pc<=pc+1, go to WHI.
  - Otherwise go to OUT.
- WHI: latches the high byte, then goes to OUT.
- OUT: `out_valid`=1 and all out_* are held stable. On `out_ready`=1:
  - `out_op`=KIL: go to HALT.
  - Otherwise, in the same cycle issue the read of the next opcode (`mem_rd`=1, addr=pc), pc<=pc+1, latch `out_pc`, and go to WOP.
- HALT: no reads, `out_valid`=0. Exits only on `pc_load`.
- Length by mode:
  - 1: Imp (includes accumulator forms, BRK, RTS, RTI, KIL).
  - 2: Imm, Zpg, ZpgX, ZpgY, IndX, IndY, Rlt.
  - 3: Abs, AbsX, AbsY, Ind.
- Decode covers the full NMOS 256-entry table, including the illegal opcodes. Examples:
  - 0x4C JMP Abs; 0x6C JMP Ind; 0x20 JSR Abs.
  - 0x80 NOP Imm; 0x0C NOP Abs.
  - 0x93 AHX IndY; 0x02/0x12/…/0xF2 KIL Imp.
- PC arithmetic is modulo 2^16: 0xFFFF+1 = 0x0000.
- `pc_load` has priority over every state:
  - pc<=`pc_in`, next state FOP, `mem_rd` forced 0 that cycle.
  - Any in-flight `mem_data` is discarded, and any partial instruction is dropped.
  - `out_valid` is 0 from the next cycle.
- If `pc_load` and an `out_valid`&`out_ready` transfer occur in the same cycle, the transfer completes and then the redirect applies.

## Timing
- Cycle 0 is the FOP cycle.
- `out_valid` rises at cycle 2 for a 1-byte instruction, cycle 3 for 2 bytes, cycle 4 for 3 bytes.
- Back-to-back throughput with `out_ready` held high: one instruction per (length+1) cycles.
  - The accept cycle doubles as the next opcode read, so there is no FOP bubble.
- `out_*` change only on entry to OUT.
- `reset` clears all state immediately, independent of `clk`. The first read requires `pc_load` after reset is released.

## Test plan
- `pc_load` 0x8000; memory A9 42 → reads at 0x8000 (cycle 0) and 0x8001 (cycle 1). Cycle 3: LDA, Imm, operand 0x0042, `out_pc` 0x8000, len 2.
- Memory 8D 34 12 with `out_ready`=1 → STA, Abs, operand 0x1234, len 3 at cycle 4. Opcode read of 0x8003 in the accept cycle.
- Hold `out_ready`=0 for 5 cycles after valid → outputs stable and `mem_rd`=0 throughout. Raising `out_ready` issues the next read the same cycle.
- `pc_load` 0xC000 during WLO → no instruction emitted for the partial fetch, and the next read is 0xC000 one cycle later.
- Opcode 0x02 → KIL, Imp, len 1, then no `mem_rd` after accept. `pc_load` 0x9000 resumes with a read of 0x9000.
- `pc_load` 0xFFFF; memory FFFF=4C, 0000=00, 0001=80 → reads FFFF, 0000, 0001. Result: JMP Abs, operand 0x8000.
- Assert `reset` mid-WHI → all outputs return to their reset values asynchronously, and no reads occur until `pc_load`.

Source files
------------

// File: rtl/insn_fetch.sv
// 6502 instruction fetch/decode: reads opcode plus 0-2 operand bytes from the bus
// and hands one decoded instruction per valid/ready handshake to execute.
package typepkg;
  localparam int DATA_N = 8;

  typedef enum logic [6:0] {
    ADC, AND, ASL, BCC, BCS, BEQ, BIT, BMI, BNE, BPL, BRK, BVC, BVS, CLC, CLD,
    CLI, CLV, CMP, CPX, CPY, DEC, DEX, DEY, EOR, INC, INX, INY, JMP, JSR, LDA,
    LDX, LDY, LSR, NOP, ORA, PHA, PHP, PLA, PLP, ROL, ROR, RTI, RTS, SBC, SEC,
    SED, SEI, STA, STX, STY, TAX, TAY, TSX, TXA, TXS, TYA,
    SLO, RLA, SRE, RRA, SAX, LAX, DCP, ISC, ANC, ALR, ARR, XAA, AXS, AHX, SHY,
    SHX, TAS, LAS, KIL
  } Opcode;

  typedef enum logic [3:0] {
    Imp, Imm, Zpg, ZpgX, ZpgY, IndX, IndY, Rlt, Abs, AbsX, AbsY, Ind
  } Addressing;
endpackage

module insn_fetch
  import typepkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_load,
  input  logic [15:0]       pc_in,
  output logic [15:0]       mem_addr,
  output logic              mem_rd,
  input  logic [DATA_N-1:0] mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output Opcode             out_op,
  output Addressing         out_mode,
  output logic [15:0]       out_operand,
  output logic [15:0]       out_pc,
  output logic [1:0]        out_len
);

  typedef enum logic [2:0] {IDLE, FOP, WOP, WLO, WHI, OUT, HALT} state_t;

  state_t      state_r;
  logic [15:0] pc_r;
  logic [15:0] insn_pc_r;
  Opcode       op_r;
  Addressing   mode_r;
  logic [1:0]  len_r;
  logic [7:0]  lo_r;
  Opcode       dec_op_s;
  Addressing   dec_mode_s;
  logic [1:0]  dec_len_s;

  function automatic Opcode alu_op(input logic [2:0] a);
    case (a)
      3'd0:    return ORA;
      3'd1:    return AND;
      3'd2:    return EOR;
      3'd3:    return ADC;
      3'd4:    return STA;
      3'd5:    return LDA;
      3'd6:    return CMP;
      default: return SBC;
    endcase
  endfunction

  function automatic Opcode rmw_op(input logic [2:0] a);
    case (a)
      3'd0:    return ASL;
      3'd1:    return ROL;
      3'd2:    return LSR;
      3'd3:    return ROR;
      3'd4:    return STX;
      3'd5:    return LDX;
      3'd6:    return DEC;
      default: return INC;
    endcase
  endfunction

  function automatic Opcode ill_op(input logic [2:0] a);
    case (a)
      3'd0:    return SLO;
      3'd1:    return RLA;
      3'd2:    return SRE;
      3'd3:    return RRA;
      3'd4:    return SAX;
      3'd5:    return LAX;
      3'd6:    return DCP;
      default: return ISC;
    endcase
  endfunction

  // Column cc=00: control flow, branches, flag ops, X/Y compares and loads.
  function automatic Opcode dec_op_c0(input logic [2:0] a, input logic [2:0] m);
    case (m)
      3'd0: case (a)
        3'd0: return BRK;  3'd1: return JSR;  3'd2: return RTI;  3'd3: return RTS;
        3'd4: return NOP;  3'd5: return LDY;  3'd6: return CPY;  default: return CPX;
      endcase
      3'd1: case (a)
        3'd1: return BIT;  3'd4: return STY;  3'd5: return LDY;  3'd6: return CPY;
        3'd7: return CPX;  default: return NOP;
      endcase
      3'd2: case (a)
        3'd0: return PHP;  3'd1: return PLP;  3'd2: return PHA;  3'd3: return PLA;
        3'd4: return DEY;  3'd5: return TAY;  3'd6: return INY;  default: return INX;
      endcase
      3'd3: case (a)
        3'd1: return BIT;  3'd2: return JMP;  3'd3: return JMP;  3'd4: return STY;
        3'd5: return LDY;  3'd6: return CPY;  3'd7: return CPX;  default: return NOP;
      endcase
      3'd4: case (a)
        3'd0: return BPL;  3'd1: return BMI;  3'd2: return BVC;  3'd3: return BVS;
        3'd4: return BCC;  3'd5: return BCS;  3'd6: return BNE;  default: return BEQ;
      endcase
      3'd5: case (a)
        3'd4: return STY;  3'd5: return LDY;  default: return NOP;
      endcase
      3'd6: case (a)
        3'd0: return CLC;  3'd1: return SEC;  3'd2: return CLI;  3'd3: return SEI;
        3'd4: return TYA;  3'd5: return CLV;  3'd6: return CLD;  default: return SED;
      endcase
      default: case (a)
        3'd4: return SHY;  3'd5: return LDY;  default: return NOP;
      endcase
    endcase
  endfunction

  function automatic Opcode dec_op_c2(input logic [2:0] a, input logic [2:0] m);
    case (m)
      3'd0: return (a == 3'd5) ? LDX : ((a >= 3'd4) ? NOP : KIL);
      3'd2: case (a)
        3'd4: return TXA;  3'd5: return TAX;  3'd6: return DEX;  3'd7: return NOP;
        default: return rmw_op(a);
      endcase
      3'd4: return KIL;
      3'd6: case (a)
        3'd4: return TXS;  3'd5: return TSX;  default: return NOP;
      endcase
      3'd7: return (a == 3'd4) ? SHX : rmw_op(a);
      default: return rmw_op(a);
    endcase
  endfunction

  function automatic Opcode dec_op_c3(input logic [2:0] a, input logic [2:0] m);
    if (m == 3'd2) begin
      case (a)
        3'd0, 3'd1: return ANC;
        3'd2:       return ALR;
        3'd3:       return ARR;
        3'd4:       return XAA;
        3'd5:       return LAX;
        3'd6:       return AXS;
        default:    return SBC;
      endcase
    end else if ((a == 3'd4) && ((m == 3'd4) || (m == 3'd7))) begin
      return AHX;
    end else if ((a == 3'd4) && (m == 3'd6)) begin
      return TAS;
    end else if ((a == 3'd5) && (m == 3'd6)) begin
      return LAS;
    end else begin
      return ill_op(a);
    end
  endfunction

  function automatic Opcode dec_op(input logic [7:0] b);
    case (b[1:0])
      2'b00:   return dec_op_c0(b[7:5], b[4:2]);
      2'b01:   return (b == 8'h89) ? NOP : alu_op(b[7:5]);
      2'b10:   return dec_op_c2(b[7:5], b[4:2]);
      default: return dec_op_c3(b[7:5], b[4:2]);
    endcase
  endfunction

  // X-register forms (STX/LDX/SAX/LAX/SHX/AHX) index by Y instead of X.
  function automatic Addressing dec_mode(input logic [7:0] b);
    logic [2:0] a;
    logic [2:0] m;
    logic       y_idx;
    a     = b[7:5];
    m     = b[4:2];
    y_idx = (a == 3'd4) || (a == 3'd5);
    case (b[1:0])
      2'b00: case (m)
        3'd0:    return (a == 3'd1) ? Abs : ((a >= 3'd4) ? Imm : Imp);
        3'd1:    return Zpg;
        3'd2:    return Imp;
        3'd3:    return (a == 3'd3) ? Ind : Abs;
        3'd4:    return Rlt;
        3'd5:    return ZpgX;
        3'd6:    return Imp;
        default: return AbsX;
      endcase
      2'b10: case (m)
        3'd0:    return (a >= 3'd4) ? Imm : Imp;
        3'd1:    return Zpg;
        3'd3:    return Abs;
        3'd5:    return y_idx ? ZpgY : ZpgX;
        3'd7:    return y_idx ? AbsY : AbsX;
        default: return Imp;
      endcase
      default: case (m)
        3'd0:    return IndX;
        3'd1:    return Zpg;
        3'd2:    return Imm;
        3'd3:    return Abs;
        3'd4:    return IndY;
        3'd5:    return (b[1] && y_idx) ? ZpgY : ZpgX;
        3'd6:    return AbsY;
        default: return (b[1] && y_idx) ? AbsY : AbsX;
      endcase
    endcase
  endfunction

  function automatic logic [1:0] mode_len(input Addressing md);
    case (md)
      Imp:                                  return 2'd1;
      Imm, Zpg, ZpgX, ZpgY, IndX, IndY, Rlt: return 2'd2;
      default:                              return 2'd3;
    endcase
  endfunction

  // Decode of whatever byte is on the bus; consumed only in WOP.
  always_comb begin
    dec_op_s   = dec_op(mem_data);
    dec_mode_s = dec_mode(mem_data);
    dec_len_s  = mode_len(dec_mode_s);
  end

  // Read strobe; in WOP it follows the freshly decoded length with no register stage.
  always_comb begin
    mem_rd = 1'b0;
    if (pc_load) begin
      mem_rd = 1'b0;
    end else begin
      case (state_r)
        FOP:     mem_rd = 1'b1;
        WOP:     mem_rd = (dec_len_s != 2'd1);
        WLO:     mem_rd = (len_r == 2'd3);
        OUT:     mem_rd = out_ready && (out_op != KIL);
        default: mem_rd = 1'b0;
      endcase
    end
  end

  assign mem_addr = pc_r;

  // Fetch sequencer; out_* are only written on entry to OUT so they stay stable while presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      pc_r        <= 16'h0000;
      insn_pc_r   <= 16'h0000;
      op_r        <= NOP;
      mode_r      <= Imp;
      len_r       <= 2'd1;
      lo_r        <= 8'h00;
      out_valid   <= 1'b0;
      out_op      <= NOP;
      out_mode    <= Imp;
      out_operand <= 16'h0000;
      out_pc      <= 16'h0000;
      out_len     <= 2'd1;
    end else if (pc_load) begin
      pc_r      <= pc_in;
      state_r   <= FOP;
      out_valid <= 1'b0;
    end else begin
      case (state_r)
        FOP: begin
          insn_pc_r <= pc_r;
          pc_r      <= pc_r + 16'd1;
          state_r   <= WOP;
        end
        WOP: begin
          op_r   <= dec_op_s;
          mode_r <= dec_mode_s;
          len_r  <= dec_len_s;
          if (dec_len_s == 2'd1) begin
            state_r     <= OUT;
            out_valid   <= 1'b1;
            out_op      <= dec_op_s;
            out_mode    <= dec_mode_s;
            out_operand <= 16'h0000;
            out_pc      <= insn_pc_r;
            out_len     <= 2'd1;
          end else begin
            pc_r    <= pc_r + 16'd1;
            state_r <= WLO;
          end
        end
        WLO: begin
          lo_r <= mem_data;
          if (len_r == 2'd3) begin
            pc_r    <= pc_r + 16'd1;
            state_r <= WHI;
          end else begin
            state_r     <= OUT;
            out_valid   <= 1'b1;
            out_op      <= op_r;
            out_mode    <= mode_r;
            out_operand <= {8'h00, mem_data};
            out_pc      <= insn_pc_r;
            out_len     <= len_r;
          end
        end
        WHI: begin
          state_r     <= OUT;
          out_valid   <= 1'b1;
          out_op      <= op_r;
          out_mode    <= mode_r;
          out_operand <= {mem_data, lo_r};
          out_pc      <= insn_pc_r;
          out_len     <= len_r;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_op == KIL) begin
              state_r <= HALT;
            end else begin
              insn_pc_r <= pc_r;
              pc_r      <= pc_r + 16'd1;
              state_r   <= WOP;
            end
          end else begin
            state_r <= OUT;
          end
        end
        default: state_r <= state_r;
      endcase
    end
  end

endmodule

// File: tb/tb_insn_fetch.sv
// Directed bench for insn_fetch: stimulus queues the expected bus reads and decoded
// instructions; a negedge monitor retires them as the DUT reads and hands off.
`timescale 1ns/1ps
module tb_insn_fetch;
  import typepkg::*;

  typedef struct packed {
    Opcode       op;
    Addressing   mode;
    logic [15:0] operand;
    logic [15:0] pc;
    logic [1:0]  len;
  } ins_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_load;
  logic [15:0] pc_in;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        out_valid;
  logic        out_ready;
  Opcode       out_op;
  Addressing   out_mode;
  logic [15:0] out_operand;
  logic [15:0] out_pc;
  logic [1:0]  out_len;

  logic [7:0]  mem [0:65535];
  logic [15:0] exp_rd [$];
  ins_t        exp_ins [$];
  logic [15:0] mon_a;
  ins_t        mon_e;
  ins_t        mon_g;
  logic [15:0] wa;
  int          n_vec = 0;
  int          n_miss = 0;

  always #5 clk = ~clk;

  insn_fetch dut (
    .clk(clk), .reset(reset), .pc_load(pc_load), .pc_in(pc_in),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_mode(out_mode), .out_operand(out_operand), .out_pc(out_pc),
    .out_len(out_len)
  );

  // Memory answers a read on the following cycle.
  always @(posedge clk) mem_data <= mem_rd ? mem[mem_addr] : 8'hEE;

  // Monitor: retire expected reads and accepted instructions.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_rd) begin
        n_vec++;
        if (exp_rd.size() == 0) begin
          n_miss++;
          $display("FAIL rd_addr: got read of %h, required no read", mem_addr);
        end else begin
          mon_a = exp_rd.pop_front();
          if (mem_addr !== mon_a) begin
            n_miss++;
            $display("FAIL rd_addr: got %h, required %h", mem_addr, mon_a);
          end
        end
      end
      if (out_valid && out_ready) begin
        n_vec++;
        mon_g = '{out_op, out_mode, out_operand, out_pc, out_len};
        if (exp_ins.size() == 0) begin
          n_miss++;
          $display("FAIL insn: got op=%0d pc=%h, required no instruction", out_op, out_pc);
        end else begin
          mon_e = exp_ins.pop_front();
          if (mon_g !== mon_e) begin
            n_miss++;
            $display("FAIL insn: got op=%0d mode=%0d operand=%h pc=%h len=%0d, required op=%0d mode=%0d operand=%h pc=%h len=%0d",
                     mon_g.op, mon_g.mode, mon_g.operand, mon_g.pc, mon_g.len,
                     mon_e.op, mon_e.mode, mon_e.operand, mon_e.pc, mon_e.len);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h, required %h", nm, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] a);
    pc_load = 1'b1;
    pc_in   = a;
    step();
    pc_load = 1'b0;
  endtask

  // Cycles from the opcode-read cycle until out_valid, bounded.
  task automatic wait_valid(input string nm, input int n0, input int want);
    int n;
    n = n0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    chk(nm, 32'(n), 32'(want));
  endtask

  // Place one instruction at wa and queue its reads and decoded form.
  task automatic add(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                     input Opcode op, input Addressing md, input logic [15:0] opnd,
                     input logic [1:0] len);
    logic [15:0] a;
    a = wa;
    for (int i = 0; i < int'(len); i++) begin
      mem[a] = (i == 0) ? b0 : ((i == 1) ? b1 : b2);
      exp_rd.push_back(a);
      a = a + 16'd1;
    end
    exp_ins.push_back('{op, md, opnd, wa, len});
    wa = a;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"},   32'(out_valid),   32'(1'b0));
    chk({tag, "_rd"},      32'(mem_rd),      32'(1'b0));
    chk({tag, "_addr"},    32'(mem_addr),    32'(16'h0000));
    chk({tag, "_op"},      32'(out_op),      32'(NOP));
    chk({tag, "_mode"},    32'(out_mode),    32'(Imp));
    chk({tag, "_operand"}, 32'(out_operand), 32'(16'h0000));
    chk({tag, "_pc"},      32'(out_pc),      32'(16'h0000));
    chk({tag, "_len"},     32'(out_len),     32'(2'd1));
  endtask

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    reset = 1'b0; pc_load = 1'b0; pc_in = 16'h0000; out_ready = 1'b0;
    #2 reset = 1'b1;
    #1 chk_reset_vals("rst");
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_valid", 32'(out_valid), 32'(1'b0));
    end

    // LDA #$42 held with out_ready low, then STA $1234 and KIL back to back.
    wa = 16'h8000;
    add(8'hA9, 8'h42, 8'h00, LDA, Imm, 16'h0042, 2'd2);
    load(16'h8000);
    wait_valid("lat_lda", 0, 3);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid",   32'(out_valid),   32'(1'b1));
      chk("hold_rd",      32'(mem_rd),      32'(1'b0));
      chk("hold_operand", 32'(out_operand), 32'(16'h0042));
      chk("hold_pc",      32'(out_pc),      32'(16'h8000));
      step();
    end
    add(8'h8D, 8'h34, 8'h12, STA, Abs, 16'h1234, 2'd3);
    add(8'h02, 8'h00, 8'h00, KIL, Imp, 16'h0000, 2'd1);
    out_ready = 1'b1;
    #1;
    chk("accept_rd",   32'(mem_rd),   32'(1'b1));
    chk("accept_addr", 32'(mem_addr), 32'(16'h8002));
    step();
    wait_valid("lat_sta", 1, 4);
    step();
    wait_valid("lat_kil", 1, 2);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("halt_valid", 32'(out_valid), 32'(1'b0));
      chk("halt_rd",    32'(mem_rd),    32'(1'b0));
    end

    // Resume after KIL.
    wa = 16'h9000;
    add(8'hEA, 8'h00, 8'h00, NOP, Imp, 16'h0000, 2'd1);
    add(8'h02, 8'h00, 8'h00, KIL, Imp, 16'h0000, 2'd1);
    load(16'h9000);
    wait_valid("lat_resume", 0, 2);
    step();
    wait_valid("lat_kil2", 1, 2);
    step(); step();

    // Redirect while the low byte of LDA $2000 is arriving.
    mem[16'hA000] = 8'hAD; mem[16'hA001] = 8'h00; mem[16'hA002] = 8'h20;
    exp_rd.push_back(16'hA000);
    exp_rd.push_back(16'hA001);
    wa = 16'hC000;
    add(8'h0A, 8'h00, 8'h00, ASL, Imp, 16'h0000, 2'd1);
    add(8'h02, 8'h00, 8'h00, KIL, Imp, 16'h0000, 2'd1);
    load(16'hA000);
    step(); step();
    pc_load = 1'b1;
    pc_in   = 16'hC000;
    #1 chk("redir_rd", 32'(mem_rd), 32'(1'b0));
    step();
    pc_load = 1'b0;
    wait_valid("lat_redir", 0, 2);
    step();
    wait_valid("lat_kil3", 1, 2);
    step(); step();

    // Fetch wraps across 0xFFFF.
    wa = 16'hFFFF;
    add(8'h4C, 8'h00, 8'h80, JMP, Abs, 16'h8000, 2'd3);
    add(8'h02, 8'h00, 8'h00, KIL, Imp, 16'h0000, 2'd1);
    load(16'hFFFF);
    wait_valid("lat_wrap", 0, 4);
    step();
    wait_valid("lat_kil4", 1, 2);
    step(); step();

    // Decode table spot checks, including illegal opcodes and Y-indexed X forms.
    wa = 16'h4000;
    add(8'h6C, 8'h00, 8'h30, JMP, Ind,  16'h3000, 2'd3);
    add(8'h93, 8'h10, 8'h00, AHX, IndY, 16'h0010, 2'd2);
    add(8'h80, 8'h55, 8'h00, NOP, Imm,  16'h0055, 2'd2);
    add(8'h0C, 8'h11, 8'h22, NOP, Abs,  16'h2211, 2'd3);
    add(8'h20, 8'hCD, 8'hAB, JSR, Abs,  16'hABCD, 2'd3);
    add(8'hB7, 8'h44, 8'h00, LAX, ZpgY, 16'h0044, 2'd2);
    add(8'h9E, 8'h00, 8'h01, SHX, AbsY, 16'h0100, 2'd3);
    add(8'hB1, 8'h20, 8'h00, LDA, IndY, 16'h0020, 2'd2);
    add(8'hD0, 8'hFE, 8'h00, BNE, Rlt,  16'h00FE, 2'd2);
    add(8'h00, 8'h00, 8'h00, BRK, Imp,  16'h0000, 2'd1);
    add(8'h60, 8'h00, 8'h00, RTS, Imp,  16'h0000, 2'd1);
    add(8'h96, 8'h12, 8'h00, STX, ZpgY, 16'h0012, 2'd2);
    add(8'hEB, 8'h07, 8'h00, SBC, Imm,  16'h0007, 2'd2);
    add(8'h02, 8'h00, 8'h00, KIL, Imp,  16'h0000, 2'd1);
    load(16'h4000);
    n = 0;
    while (exp_ins.size() != 0 && n < 400) begin
      step();
      n++;
    end
    chk("batch_drain", 32'(exp_ins.size()), 32'd0);
    step(); step();

    // Asynchronous reset while waiting on the high byte of STA $5678.
    mem[16'h5000] = 8'h8D; mem[16'h5001] = 8'h78; mem[16'h5002] = 8'h56;
    exp_rd.push_back(16'h5000);
    exp_rd.push_back(16'h5001);
    exp_rd.push_back(16'h5002);
    load(16'h5000);
    step(); step(); step();
    #1 reset = 1'b1;
    #1 chk_reset_vals("mid_rst");
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_valid", 32'(out_valid), 32'(1'b0));
      chk("post_rst_rd",    32'(mem_rd),    32'(1'b0));
    end

    chk("rd_drained",  32'(exp_rd.size()),  32'd0);
    chk("ins_drained", 32'(exp_ins.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
